// File: rtl/ym_write_sequencer.sv
// Write FIFO and bus sequencer for the YM bank.
// Replays host writes in order, honouring strobe width and per-chip busy time.
module ym_write_sequencer #(
    parameter int YM_COUNT   = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int WR_CYCLES  = 12,
    parameter int ADDR_WAIT  = 102,
    parameter int DATA_WAIT  = 498
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_wr,
    input  logic [4:0]                    in_cs,
    input  logic [1:0]                    in_addr,
    input  logic [7:0]                    in_din,
    input  logic                          clr_ovf,
    output logic [4:0]                    ym_cs,
    output logic [1:0]                    ym_addr,
    output logic [7:0]                    ym_din,
    output logic                          ym_wr_n,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          busy,
    output logic                          ovf
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int TW  = $clog2(DATA_WAIT + 1);
    localparam int CNW = $clog2(WR_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [14:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            ovf_q, ovf_d;
    logic [CNW-1:0]  cnt_q, cnt_d;
    logic [4:0]      cs_q;
    logic [1:0]      addr_q;
    logic [7:0]      din_q;
    logic [TW-1:0]   t_q [1:YM_COUNT];

    logic [14:0]     head;
    logic [4:0]      head_cs;
    logic            head_valid, head_free, timers_busy;
    logic            push, pop, latch;

    assign head       = mem_q[rd_ptr_q];
    assign head_cs    = head[14:10];
    assign head_valid = (head_cs != 5'd0) && (int'(head_cs) <= YM_COUNT);

    assign full = (level_q == LW'(FIFO_DEPTH));
    assign push = in_wr && !full;
    assign ovf_d = (in_wr && full) || (ovf_q && !clr_ovf);

    always_comb begin
        head_free   = 1'b0;
        timers_busy = 1'b0;
        for (int k = 1; k <= YM_COUNT; k++) begin
            if (head_cs == 5'(k)) head_free = (t_q[k] == '0);
            if (t_q[k] != '0) timers_busy = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    if (!head_valid) begin
                        pop = 1'b1;
                    end else if (head_free) begin
                        pop     = 1'b1;
                        latch   = 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == CNW'(WR_CYCLES - 1)) state_d = S_HOLD;
                else cnt_d = cnt_q + 1'b1;
            end
            S_HOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_cs, in_addr, in_din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            cs_q     <= '0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
            if (latch) begin
                cs_q   <= head_cs;
                addr_q <= head[9:8];
                din_q  <= head[7:0];
            end
        end
    end

    // Reload happens on the HOLD cycle; issue requires zero, so no live reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= YM_COUNT; k++) t_q[k] <= '0;
        end else begin
            for (int k = 1; k <= YM_COUNT; k++) begin
                if (state_q == S_HOLD && cs_q == 5'(k))
                    t_q[k] <= addr_q[0] ? TW'(DATA_WAIT) : TW'(ADDR_WAIT);
                else if (t_q[k] != '0)
                    t_q[k] <= t_q[k] - 1'b1;
            end
        end
    end

    assign ym_cs   = (state_q == S_IDLE) ? 5'd0 : cs_q;
    assign ym_addr = addr_q;
    assign ym_din  = din_q;
    assign ym_wr_n = (state_q != S_STROBE);
    assign level   = level_q;
    assign ovf     = ovf_q;
    assign busy    = (level_q != '0) || (state_q != S_IDLE) || timers_busy;

endmodule

// File: tb/tb_ym_write_sequencer.sv
// Scoreboard bench for ym_write_sequencer: order, timing and FIFO limits.
module tb_ym_write_sequencer;

    localparam int WR = 12;
    localparam int AW = 102;
    localparam int DW = 498;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_wr = 1'b0;
    logic [4:0] in_cs = '0;
    logic [1:0] in_addr = '0;
    logic [7:0] in_din = '0;
    logic       clr_ovf = 1'b0;
    logic [4:0] ym_cs;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic       ym_wr_n;
    logic [4:0] level;
    logic       full, busy, ovf;

    ym_write_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_wr(in_wr), .in_cs(in_cs),
        .in_addr(in_addr), .in_din(in_din), .clr_ovf(clr_ovf),
        .ym_cs(ym_cs), .ym_addr(ym_addr), .ym_din(ym_din),
        .ym_wr_n(ym_wr_n), .level(level), .full(full),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [14:0] sb[$];
    int setup_log[$];
    int low_log[$];
    int hold_log[$];
    int next_ok[32];
    bit mon_en = 1'b0;
    logic [4:0] prev_cs = '0;
    logic prev_wrn = 1'b1;
    int lowcnt = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ym_cs != 0 && prev_cs == 0) begin
                setup_log.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got cs=%0d a=%0d d=%h, none expected",
                             ym_cs, ym_addr, ym_din);
                end else begin
                    logic [14:0] e;
                    e = sb.pop_front();
                    if ({ym_cs, ym_addr, ym_din} !== e) begin
                        errors++;
                        $display("FAIL sb_order: got %h expected %h",
                                 {ym_cs, ym_addr, ym_din}, e);
                    end
                end
                checks++;
                if (cyc < next_ok[ym_cs]) begin
                    errors++;
                    $display("FAIL chip_gap: cs=%0d setup at %0d, earliest %0d",
                             ym_cs, cyc, next_ok[ym_cs]);
                end
                checks++;
                if (ym_wr_n !== 1'b1) begin
                    errors++;
                    $display("FAIL setup_wrn: got %b expected 1", ym_wr_n);
                end
            end
            if (ym_wr_n == 1'b0) begin
                if (prev_wrn) low_log.push_back(cyc);
                lowcnt++;
                if (ym_cs == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_cs: got cs=0 during strobe, expected nonzero");
                end
            end else if (!prev_wrn) begin
                hold_log.push_back(cyc);
                checks++;
                if (lowcnt != WR) begin
                    errors++;
                    $display("FAIL strobe_width: got %0d expected %0d", lowcnt, WR);
                end
                next_ok[ym_cs] = cyc + 2 + (ym_addr[0] ? DW : AW);
                lowcnt = 0;
            end
        end
        prev_cs = ym_cs;
        prev_wrn = ym_wr_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        setup_log.delete();
        low_log.delete();
        hold_log.delete();
    endtask

    task automatic drive_wr(input logic [4:0] cs, input logic [1:0] a,
                            input logic [7:0] d, input bit exp, output int c);
        in_wr = 1'b1;
        in_cs = cs;
        in_addr = a;
        in_din = d;
        c = cyc;
        if (exp) sb.push_back({cs, a, d});
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic wait_holds(input int n, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            #1;
            if (hold_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        int c;
        bit ok;
        repeat (2) tick();
        checks++;
        if (ym_wr_n !== 1'b1 || ym_cs !== 5'd0 || level !== 5'd0) begin
            errors++;
            $display("FAIL rst_hold: wr_n=%b cs=%0d lvl=%0d expected 1/0/0",
                     ym_wr_n, ym_cs, level);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ym_cs, ym_addr, ym_din} !== 15'd0 || ym_wr_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_bus: got %h/%b expected 0/1",
                     {ym_cs, ym_addr, ym_din}, ym_wr_n);
        end
        checks++;
        if (level !== 5'd0 || full !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: lvl=%0d full=%b busy=%b ovf=%b expected 0",
                     level, full, busy, ovf);
        end
        drive_wr(5'd3, 2'd1, 8'hA5, 1'b0, c);
        drive_wr(5'd3, 2'd0, 8'h5A, 1'b0, c);
        ok = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ym_wr_n == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_strobe_timeout: got no strobe, expected one");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 5'd1) begin
            errors++;
            $display("FAIL rst_pre_level: got %0d expected 1", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ym_wr_n !== 1'b1 || ym_cs !== 5'd0) begin
            errors++;
            $display("FAIL rst_async_bus: wr_n=%b cs=%0d expected 1/0", ym_wr_n, ym_cs);
        end
        checks++;
        if (level !== 5'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_flags: lvl=%0d ovf=%b busy=%b expected 0",
                     level, ovf, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        sb.delete();
        clear_logs();
        for (int k = 0; k < 32; k++) next_ok[k] = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        int c;
        int h;
        bit ok;
        clear_logs();
        drive_wr(5'd3, 2'd1, 8'hA5, 1'b1, c);
        wait_holds(1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: got no HOLD, expected one");
            return;
        end
        checks++;
        if (setup_log[0] != c + 2 || low_log[0] != c + 3 || hold_log[0] != c + 3 + WR) begin
            errors++;
            $display("FAIL single_timing: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     setup_log[0] - c, low_log[0] - c, hold_log[0] - c, 2, 3, 3 + WR);
        end
        h = hold_log[0];
        while (cyc < h + DW) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_end: got %b expected 1 at HOLD+%0d", busy, DW);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_clear: got %b expected 0 at HOLD+%0d", busy, DW + 1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        bit ok;
        wait_idle(2000, ok);
        clear_logs();
        drive_wr(5'd1, 2'd0, 8'h11, 1'b1, c);
        drive_wr(5'd1, 2'd1, 8'h22, 1'b1, c);
        wait_holds(2, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_same_timeout: got %0d holds expected 2", hold_log.size());
        end else if (setup_log[1] - hold_log[0] != AW + 2) begin
            errors++;
            $display("FAIL b2b_same_gap: got %0d expected %0d",
                     setup_log[1] - hold_log[0], AW + 2);
        end
        wait_idle(2000, ok);
        clear_logs();
        drive_wr(5'd1, 2'd0, 8'h33, 1'b1, c);
        drive_wr(5'd2, 2'd0, 8'h44, 1'b1, c);
        wait_holds(2, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_diff_timeout: got %0d holds expected 2", hold_log.size());
        end else if (setup_log[1] - hold_log[0] != 2) begin
            errors++;
            $display("FAIL b2b_diff_gap: got %0d expected 2", setup_log[1] - hold_log[0]);
        end
    endtask

    task automatic test_overflow();
        int c;
        bit ok;
        wait_idle(2000, ok);
        clear_logs();
        drive_wr(5'd4, 2'd1, 8'h55, 1'b1, c);
        wait_holds(1, 100, ok);
        for (int i = 0; i < 17; i++)
            drive_wr(5'd4, 2'd0, 8'(i), i < 16, c);
        checks++;
        if (level !== 5'd16 || full !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: lvl=%0d full=%b ovf=%b expected 16/1/1",
                     level, full, ovf);
        end
        clr_ovf = 1'b1;
        drive_wr(5'd4, 2'd0, 8'hEE, 1'b0, c);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || level !== 5'd16) begin
            errors++;
            $display("FAIL ovf_set_prio: ovf=%b lvl=%0d expected 1/16", ovf, level);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
        wait_holds(17, 3500, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain: holds=%0d pending=%0d expected 17/0",
                     hold_log.size(), sb.size());
        end
    endtask

    task automatic test_invalid_cs();
        int c0;
        int c;
        bit ok;
        wait_idle(4000, ok);
        clear_logs();
        drive_wr(5'd0, 2'd0, 8'h01, 1'b0, c0);
        drive_wr(5'd10, 2'd1, 8'h02, 1'b0, c);
        drive_wr(5'd5, 2'd0, 8'h77, 1'b1, c);
        wait_holds(1, 100, ok);
        repeat (20) tick();
        checks++;
        if (!ok || low_log.size() != 1 || hold_log.size() != 1) begin
            errors++;
            $display("FAIL inv_pulses: got %0d strobes expected 1", low_log.size());
        end
        checks++;
        if (ok && setup_log[0] != c0 + 4) begin
            errors++;
            $display("FAIL inv_timing: got setup at +%0d expected +4", setup_log[0] - c0);
        end
        checks++;
        if (level !== 5'd0) begin
            errors++;
            $display("FAIL inv_level: got %0d expected 0", level);
        end
    endtask

    task automatic test_random();
        int c;
        bit ok;
        logic [4:0] cs;
        logic [1:0] a;
        wait_idle(4000, ok);
        repeat (10000) begin
            if ($urandom_range(0, 39) == 0 && !full) begin
                cs = 5'($urandom_range(0, 11));
                a = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0)};
                drive_wr(cs, a, 8'($urandom_range(0, 255)),
                         cs != 0 && cs <= 9, c);
            end else begin
                tick();
            end
        end
        wait_idle(30000, ok);
        checks++;
        if (!ok || sb.size() != 0 || level !== 5'd0) begin
            errors++;
            $display("FAIL rand_drain: pending=%0d lvl=%0d expected 0/0", sb.size(), level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_invalid_cs();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
